apb_ram_slave: RTL

Parametrised APB3 memory-mapped slave, successor to the fixed 8-bit/64-entry slave in the bus fabric. Provides a word-addressed RAM of configurable width and depth behind a standard APB setup/access handshake. Adds programmable wait states, registered read data and PSLVERR for out-of-range addresses. Sits behind the APB master/decoder alongside the existing slaves, one PSEL per instance.

---
 rtl/apb_ram_pkg.sv | 24 ++
 rtl/apb_ram_slave_if.sv | 39 +++
 rtl/apb_ram_mem.sv | 33 +++
 rtl/apb_ram_slave.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/apb_ram_pkg.sv
// Shared types and constants for the APB RAM slave: FSM encoding, wait-counter
// width and the parameter-legality helper used at elaboration.
package apb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = (1 << CNT_W) - 1;

    // True when the width/depth/wait-state combination can be built.
    function automatic bit params_ok(input int data_w, input int addr_w,
                                     input int depth, input int wait_cycles);
        bit ok;
        ok = (data_w >= 8) && (data_w % 8 == 0) && (depth >= 1) && (addr_w >= 1);
        if (addr_w < 31) ok = ok && (depth <= (1 << addr_w));
        ok = ok && (wait_cycles >= 0) && (wait_cycles <= MAX_WAIT);
        return ok;
    endfunction

endpackage

// File: rtl/apb_ram_slave_if.sv
// APB3 signal bundle for one slave select. PSTRB exists only when
// APB_RAM_PSTRB_EN is defined.
interface apb_ram_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
`ifdef APB_RAM_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;
`endif
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
    // access cycles (PSEL=1, PENABLE=1) that end in the cycle PREADY=1; the
    // master holds PADDR/PWRITE/PWDATA/PSTRB stable until then, and PSLVERR
    // is meaningful only in that PREADY cycle.
    modport master (
`ifdef APB_RAM_PSTRB_EN
        output PSTRB,
`endif
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
`ifdef APB_RAM_PSTRB_EN
        input  PSTRB,
`endif
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_ram_mem.sv
// DEPTH x DATA_W storage: synchronous byte-enabled write, synchronous read
// whose output register holds its value while i_re is low.
module apb_ram_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [AW-1:0]       i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_re,
    input  logic [AW-1:0]       i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_ram_slave.sv
// APB3 RAM slave: FSM, request latching, range check and response registers.
// Byte strobes are supported when APB_RAM_PSTRB_EN is defined.
module apb_ram_slave
    import apb_ram_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_ram_slave_if.slave  apb,
    output state_t          o_dbg_state
);
    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!params_ok(DATA_W, ADDR_W, DEPTH, WAIT_CYCLES)) begin : g_bad_params
        $fatal(1, "apb_ram_slave: illegal DATA_W/ADDR_W/DEPTH/WAIT_CYCLES");
    end

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_strb;
    logic              r_oor;
    logic              r_pready;
    logic              r_pslverr;
    logic              r_rd_zero;

    logic              w_setup;
    logic              w_oor;
    logic [NB-1:0]     w_strb_in;
    logic              w_to_ack;
    logic              w_cur_write;
    logic              w_cur_oor;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_mem_rdata;

`ifdef APB_RAM_PSTRB_EN
    assign w_strb_in = apb.PSTRB;
`else
    assign w_strb_in = '1;
`endif

    assign w_setup = apb.PSEL && !apb.PENABLE;
    assign w_oor   = ({1'b0, apb.PADDR} >= (ADDR_W + 1)'(DEPTH));

    // The read is issued on the edge that enters ACK, so the address comes
    // straight off the bus when there are no wait states.
    always_comb begin
        w_to_ack    = 1'b0;
        w_cur_write = r_write;
        w_cur_oor   = r_oor;
        w_rd_addr   = r_addr;
        case (r_state)
            IDLE: begin
                w_cur_write = apb.PWRITE;
                w_cur_oor   = w_oor;
                w_rd_addr   = apb.PADDR;
                w_to_ack    = w_setup && (WAIT_CYCLES == 0);
            end
            WAIT:    w_to_ack = apb.PSEL && (r_cnt == CNT_W'(1));
            default: ;
        endcase
    end

    assign w_re = w_to_ack && !w_cur_write && !w_cur_oor;
    assign w_we = (r_state == ACK) && r_write && !r_oor;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_oor     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_addr  <= apb.PADDR;
                        r_write <= apb.PWRITE;
                        r_wdata <= apb.PWDATA;
                        r_strb  <= w_strb_in;
                        r_oor   <= w_oor;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= ACK;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_oor;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!apb.PSEL) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state   <= ACK;
                        r_pready  <= 1'b1;
                        r_pslverr <= r_oor;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // Read data persists across writes and idle time; an out-of-range
            // read forces it to zero until the next good read.
            if (w_to_ack && !w_cur_write) r_rd_zero <= w_cur_oor;
        end
    end

    apb_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .i_clk   (PCLK),
        .i_we    (w_we),
        .i_be    (r_strb),
        .i_waddr (r_addr[MEM_AW-1:0]),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_raddr (w_rd_addr[MEM_AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign apb.PRDATA  = r_rd_zero ? '0 : w_mem_rdata;
    assign apb.PREADY  = r_pready;
    assign apb.PSLVERR = r_pslverr;
    assign o_dbg_state = r_state;

endmodule
